// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the digit-serial multiplier controller.
// Used by mul_seq_ctrl and mul2x2 (optional build macro MUL_SEQ_ZERO_SKIP_EN
// only affects mul_seq_ctrl).
package mul_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one operand digit fed to the shared 2x2 multiplier
  localparam int DIGW = 2;

  // Number of DIGW-bit digits in a W-bit operand
  function automatic int num_digits(input int w);
    return w / DIGW;
  endfunction

endpackage

// File: rtl/mul2x2.sv
// Purely combinational 2-bit x 2-bit unsigned multiplier; the single
// arithmetic resource shared by every partial product of mul_seq_ctrl.
module mul2x2
  import mul_seq_pkg::*;
(
  input  logic [DIGW-1:0]   x,
  input  logic [DIGW-1:0]   y,
  output logic [2*DIGW-1:0] p
);

  assign p = {{DIGW{1'b0}}, x} * {{DIGW{1'b0}}, y};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: one 2x2 partial product per cycle,
// accumulated into a 2W-bit register, valid/ready on both sides.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: a zero operand finishes one
// edge after accept instead of running the full partial-product sweep.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one partial product per cycle over digit indices (i, j)
// DONE  | product held on y with out_valid until out_ready
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           busy
);

  localparam int D  = num_digits(W);
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int SW = $clog2(2 * W);
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  if ((W % 2) != 0 || W < 4 || W > 8) begin : g_w_check
    $error("mul_seq_ctrl: W must be even and within 4..8");
  end

  state_t              state_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [2*W-1:0]      acc_q;
  logic [IW-1:0]       i_q;
  logic [IW-1:0]       j_q;
  logic [2*W-1:0]      y_q;
  logic                out_valid_q;

  logic [DIGW-1:0]     dig_a;
  logic [DIGW-1:0]     dig_b;
  logic [2*DIGW-1:0]   pp;
  logic [2*W-1:0]      pp_ext;
  logic [SW-1:0]       shift_amt;
  logic [2*W-1:0]      acc_sum;
  logic                last_pp;
  logic                zero_skip;

  assign dig_a = a_q[DIGW*i_q +: DIGW];
  assign dig_b = b_q[DIGW*j_q +: DIGW];

  mul2x2 u_mul2x2 (
    .x (dig_a),
    .y (dig_b),
    .p (pp)
  );

  // Digit (i, j) carries weight 2^(2*(i+j)); the 2W-bit accumulator cannot overflow
  assign pp_ext    = {{(2*W-2*DIGW){1'b0}}, pp};
  assign shift_amt = SW'(DIGW * (int'(i_q) + int'(j_q)));
  assign acc_sum   = acc_q + (pp_ext << shift_amt);
  assign last_pp   = (i_q == LAST) && (j_q == LAST);

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign zero_skip = (a_q == '0) || (b_q == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Controller: accept, partial-product sweep, result hold and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (zero_skip) begin
            y_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (last_pp) begin
            acc_q       <= acc_sum;
            y_q         <= acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q <= acc_sum;
            if (j_q == LAST) begin
              j_q <= '0;
              i_q <= i_q + IW'(1);
            end else begin
              j_q <= j_q + IW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is withheld while reset is asserted, even though state is already IDLE
  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl at W=4 against a plain a*b reference
// with an expected-product queue.
module tb_mul_seq_ctrl;

  localparam int W = 4;
  localparam int D = W / 2;
  localparam int N = D * D;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept to out_valid, straight from the behavioural rules
  function automatic int exp_lat(input int av, input int bv);
`ifdef MUL_SEQ_ZERO_SKIP_EN
    if (av == 0 || bv == 0) return 1;
`endif
    return (av >= 0 && bv >= 0) ? N : N;
  endfunction

  // One complete transaction with an optional out_ready stall
  task automatic run_op(input int av, input int bv, input int stall);
    int lat;
    out_ready = (stall == 0);
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    check_eq("ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      lat++;
    end
    check_eq("latency", lat, exp_lat(av, bv));
    check_eq("product", y, av * bv);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_y", y, av * bv);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check_eq("release_valid", out_valid, 0);
    check_eq("release_idle", in_ready, 1);
    check_eq("release_busy", busy, 0);
    check_eq("y_retained", y, av * bv);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    int accepts[$];
    int idx;
    int got;
    int guard;
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] exp_y;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);

    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", in_ready, 1);

    run_op(3, 3, 0);
    run_op(15, 15, 0);
    run_op(10, 6, 0);
    run_op(0, 13, 0);
    run_op(13, 0, 2);
    run_op(7, 9, 10);

    // Asynchronous abort two edges into a computation
    a = 4'd12;
    b = 4'd13;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_y", y, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("abort_no_output", seen, 0);
    run_op(2, 5, 0);

    // Back-to-back accepts with in_valid held high
    a = 4'd5;
    b = 4'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (accepts.size() < 3 && guard < 40) begin
      if (in_ready) accepts.push_back(cyc);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check_eq("tput_accepts", accepts.size(), 3);
    if (accepts.size() == 3) begin
      check_eq("tput_gap1", accepts[1] - accepts[0], N + 2);
      check_eq("tput_gap2", accepts[2] - accepts[1], N + 2);
    end
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("tput_drain", in_ready, 1);

    // Exhaustive sweep with random consumer stalls
    idx = 0;
    got = 0;
    guard = 0;
    while ((idx < 256 || q.size() > 0) && guard < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_y = (q.size() > 0) ? q.pop_front() : 'x;
        check_eq("sweep_y", y, exp_y);
        got++;
      end
      if (idx < 256) begin
        in_valid = 1'b1;
        a = W'(idx >> 4);
        b = W'(idx & 15);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        q.push_back((2*W)'((idx >> 4) * (idx & 15)));
        idx++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check_eq("sweep_returned", got, 256);
    check_eq("sweep_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
